// File: rtl/dpwm_pkg.sv
// rtl/dpwm_pkg.sv - shared constants and state type for the DPWM counter/comparator
package dpwm_pkg;

  localparam int N_BITS_DEF = 8;
  // Width of the fine part; must equal the input width of the tap decoder.
  localparam int FINE_BITS  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } dpwm_state_t;

endpackage

// File: rtl/contador_periodo.sv
// rtl/contador_periodo.sv - C-bit period counter with synchronous clear and terminal flag
module contador_periodo #(
  parameter int C = 6
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [C-1:0] cnt_o,
  output logic         fin_o
);

  logic [C-1:0] cnt_q;

  // Count up modulo 2^C; clear wins over increment so a period start always lands on 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + C'(1);
    end
  end

  assign cnt_o = cnt_q;
  assign fin_o = &cnt_q;

endmodule

// File: rtl/dpwm_contador_comparador.sv
// rtl/dpwm_contador_comparador.sv - coarse PWM counter/comparator with double-buffered duty and fine tap select
module dpwm_contador_comparador
  import dpwm_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N_BITS-1:0]    duty,
  input  logic                 duty_wr,
  output logic                 duty_ack,
  output logic                 pwm_coarse,
  output logic [FINE_BITS-1:0] fine_sel,
  output logic                 pwm_ini
);

  localparam int C = N_BITS - FINE_BITS;

  dpwm_state_t          state_q;
  logic [N_BITS-1:0]    shadow_q;
  logic [N_BITS-1:0]    active_q;
  logic                 pwm_q;
  logic                 ini_q;
  logic                 ack_q;
  logic [FINE_BITS-1:0] fine_q;

  logic [C-1:0] cnt;
  logic [C-1:0] cnt_inc;
  logic [C-1:0] coarse;
  logic [C-1:0] shadow_coarse;
  logic         fin;
  logic         running;
  logic         start;

  assign running       = (state_q != IDLE);
  // A period starts after IDLE sees en, or at wrap while en is still high.
  assign start         = en && (!running || fin);
  assign cnt_inc       = cnt + C'(1);
  assign coarse        = active_q[N_BITS-1:FINE_BITS];
  assign shadow_coarse = shadow_q[N_BITS-1:FINE_BITS];

  contador_periodo #(
    .C (C)
  ) u_contador (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (start),
    .inc_i (running),
    .cnt_o (cnt),
    .fin_o (fin)
  );

  // Shadow register takes every write; ack follows the write by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      ack_q    <= 1'b0;
    end else begin
      ack_q <= duty_wr;
      if (duty_wr) begin
        shadow_q <= duty;
      end
    end
  end

  // Period FSM: loads active duty at period start, drops pwm after coarse cycles, idles at wrap without en.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      active_q <= '0;
      pwm_q    <= 1'b0;
      ini_q    <= 1'b0;
      fine_q   <= '0;
    end else begin
      ini_q <= 1'b0;
      if (start) begin
        // Active takes the shadow value as it was before this edge; a coincident write waits a period.
        active_q <= shadow_q;
        ini_q    <= 1'b1;
        fine_q   <= shadow_q[FINE_BITS-1:0];
        if (shadow_coarse != '0) begin
          state_q <= ON;
          pwm_q   <= 1'b1;
        end else begin
          state_q <= OFF;
          pwm_q   <= 1'b0;
        end
      end else if (running && fin) begin
        state_q <= IDLE;
        pwm_q   <= 1'b0;
        fine_q  <= '0;
      end else if (state_q == ON && cnt_inc == coarse) begin
        state_q <= OFF;
        pwm_q   <= 1'b0;
      end
    end
  end

  assign duty_ack   = ack_q;
  assign pwm_coarse = pwm_q;
  assign fine_sel   = fine_q;
  assign pwm_ini    = ini_q;

endmodule

// File: tb/tb_dpwm_contador_comparador.sv
// tb/tb_dpwm_contador_comparador.sv - randomized and directed bench against a period-position model
module tb_dpwm_contador_comparador;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] duty;
  logic       duty_wr;
  logic       duty_ack;
  logic       pwm_coarse;
  logic [1:0] fine_sel;
  logic       pwm_ini;

  int errors = 0;
  int checks = 0;

  // Model: running flag, position within the 64-cycle period, active and shadow duty words.
  bit         m_run;
  int         m_pos;
  logic [7:0] m_act;
  logic [7:0] m_sh;
  logic       m_ack;

  int hi_cnt    = 0;
  int last_high = -1;
  bit saw_ini;

  dpwm_contador_comparador #(.N_BITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .duty       (duty),
    .duty_wr    (duty_wr),
    .duty_ack   (duty_ack),
    .pwm_coarse (pwm_coarse),
    .fine_sel   (fine_sel),
    .pwm_ini    (pwm_ini)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic e, input logic [7:0] d, input logic w);
    if (r) begin
      m_run = 1'b0;
      m_pos = 0;
      m_act = 8'h00;
      m_sh  = 8'h00;
      m_ack = 1'b0;
    end else begin
      m_ack = w;
      if (e && (!m_run || m_pos == 63)) begin
        m_act = m_sh;
        m_pos = 0;
        m_run = 1'b1;
      end else if (m_run && m_pos == 63) begin
        m_run = 1'b0;
      end else if (m_run) begin
        m_pos++;
      end
      if (w) m_sh = d;
    end
  endtask

  // One clock: drive inputs, advance the model, then compare all outputs on the falling edge.
  task automatic step(input logic r, input logic e, input logic [7:0] d, input logic w);
    int e_coarse;
    rst     = r;
    en      = e;
    duty    = d;
    duty_wr = w;
    model_update(r, e, d, w);
    @(negedge clk);
    e_coarse = int'(m_act[7:2]);
    check("pwm_ini",    int'(pwm_ini),    (m_run && m_pos == 0) ? 1 : 0);
    check("pwm_coarse", int'(pwm_coarse), (m_run && m_pos < e_coarse) ? 1 : 0);
    check("fine_sel",   int'(fine_sel),   m_run ? int'(m_act[1:0]) : 0);
    check("duty_ack",   int'(duty_ack),   int'(m_ack));
    if (pwm_ini === 1'b1) begin
      last_high = hi_cnt;
      hi_cnt    = 1;
      saw_ini   = 1'b1;
    end else if (pwm_coarse === 1'b1) begin
      hi_cnt++;
    end
  endtask

  task automatic wait_ini();
    saw_ini = 1'b0;
    for (int i = 0; i < 70 && !saw_ini; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
    end
    if (!saw_ini) check("ini_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; duty = 8'h00; duty_wr = 1'b0;

    // Reset then zero duty for two periods.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 130; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

    // Mid-range duty written in IDLE.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'hA7, 1'b1);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    wait_ini();
    wait_ini();
    check("a7_high_cycles", last_high, 41);

    // Two writes inside an A7 period: that period unchanged, next uses 0x80.
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h40, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h80, 1'b1);
    wait_ini();
    check("a7_unchanged", last_high, 41);
    check("fine_after_dbl", int'(fine_sel), 0);
    wait_ini();
    check("x80_high_cycles", last_high, 32);

    // Write on the period-start edge lands one period later; then maximum duty.
    for (int i = 0; i < 63; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'hFF, 1'b1);
    check("start_edge_ini", int'(pwm_ini), 1);
    check("start_edge_fine", int'(fine_sel), 0);
    wait_ini();
    check("start_edge_old", last_high, 32);
    check("ff_fine", int'(fine_sel), 3);
    wait_ini();
    check("ff_high_cycles", last_high, 63);

    // Drop en early in a period: period completes, then IDLE.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 70; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    check("idle_pwm", int'(pwm_coarse), 0);

    // Reset while ON, then restart with shadow cleared.
    step(1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    check("pre_rst_on", int'(pwm_coarse), 1);
    step(1'b1, 1'b1, 8'h00, 1'b0);
    check("rst_pwm", int'(pwm_coarse), 0);
    check("rst_fine", int'(fine_sel), 0);
    for (int i = 0; i < 70; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 500) == 0, ($urandom % 16) != 0, 8'($urandom), ($urandom % 8) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dpwm_contador_comparador.md
# dpwm_contador_comparador

Counter/comparator core of the hybrid DPWM, placed directly upstream of the 2-to-4 tap decoder (Deco_2_a_4). It splits a double-buffered duty word into a coarse part, which sets the high time of `pwm_coarse` in whole clock cycles, and a 2-bit fine part, `fine_sel`, which drives the decoder to pick the delay-line tap that extends the pulse. It also marks each period start and acknowledges duty writes.

## Interface
- `N_BITS`, 8: duty word width; coarse width `C = N_BITS-2`; period is `2^C` clocks (64 by default).
- `clk` input 1: single clock, all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: run enable.
- `duty` input N_BITS: requested duty word; `[N_BITS-1:2]` is coarse, `[1:0]` is fine.
- `duty_wr` input 1: write strobe for `duty`, one cycle.
- `duty_ack` output 1: one-cycle pulse on the cycle after each accepted `duty_wr`.
- `pwm_coarse` output 1: coarse PWM output; the downstream delay line extends it from its falling edge.
- `fine_sel` output 2: tap select to the decoder's `IN`; constant for a whole period.
- `pwm_ini` output 1: high during the first cycle of every period.

## Operation
- Reset values: state IDLE, counter 0, shadow duty 0, active duty 0, `pwm_coarse`=0, `fine_sel`=0, `pwm_ini`=0, `duty_ack`=0.
- Duty path:
  - `duty_wr` loads the shadow register on every clock edge, in any state.
  - Several writes within one period: the last one wins.
  - The active register loads from shadow only on the edge that starts a period.
- FSM states are IDLE, ON and OFF. All outputs are registered.
  - IDLE: outputs at reset values. If `en`=1 is sampled, the next cycle is the first cycle of a period.
  - Period start: counter goes to 0, active duty loads from shadow, `pwm_ini`=1, `fine_sel` takes active `[1:0]`. State goes to ON if active coarse is not 0, otherwise OFF.
  - ON: `pwm_coarse`=1. The FSM moves to OFF after exactly `coarse` cycles counted from the period start.
  - OFF: `pwm_coarse`=0 until the counter wraps at `2^C-1`.
  - At wrap with `en`=1, a new period starts. At wrap with `en`=0, the FSM goes to IDLE.
- `en` falling mid-period does not cut the period short; the current period completes first.
- Boundary cases:
  - coarse=0: `pwm_coarse` stays low for the whole period. `fine_sel` is still driven, but there is no extension; this is the documented minimum-duty floor.
  - coarse=`2^C-1`: high for 63 cycles, low for 1. There is no 100 % duty.
  - The counter wraps modulo `2^C` and has no overflow flag.
- `rst` asserted in any state forces all reset values on the next edge, including the shadow register.

## Timing
- Latency from `en` sampled high in IDLE to the `pwm_ini` cycle: 1 clock.
- `pwm_ini`, the first `pwm_coarse` high cycle, and the new `fine_sel` value all appear in the same cycle.
- Latency from `duty_wr` to `duty_ack`: 1 clock.
- A write whose edge coincides with a period-start edge lands in shadow only and takes effect one period later.
- A write on any earlier edge of the period takes effect at the next period start.
- `fine_sel` changes only on period-start edges, so the decoder output is glitch-free within a period.

## Structure
- Shared package `dpwm_pkg`:
  - `N_BITS_DEF` = 8.
  - `FINE_BITS` = 2, which must match the decoder input width.
  - Typedef `dpwm_state_t` {IDLE, ON, OFF}.
- Sub-module `contador_periodo`: a C-bit counter with synchronous clear and a `fin` flag that is high at `2^C-1`. The FSM and duty registers stay in the top module.

## Test plan
All scenarios use `N_BITS`=8 and a 64-clock period.
- Idle and zero duty: hold `rst` 2 cycles, then `en`=1 with duty 0x00 → `pwm_ini` every 64 cycles, `pwm_coarse` always 0, `fine_sel`=0.
- Mid-range duty: write 0xA7 in IDLE, then `en`=1 → first period `pwm_coarse` high 41 cycles from `pwm_ini`, low 23; `fine_sel`=3; `duty_ack` 1 cycle after the write.
- Maximum duty: 0xFF → high 63, low 1, `fine_sel`=3, repeated every period.
- Double buffering:
  - Write 0x40 at cycle 10 and 0x80 at cycle 20 of a 0xA7 period → that period is unchanged, the next has 32 high cycles and `fine_sel`=0, and `duty_ack` pulses twice.
  - A write on the period-start edge → applied only in the period after.
- Stop and reset:
  - `en`=0 at cycle 5 → the period finishes its full 64 cycles, then IDLE with all outputs 0.
  - `rst`=1 during ON → next cycle `pwm_coarse`=0, `fine_sel`=0, state IDLE; after release with `en`=1 and no new write, the period runs with duty 0.
